// File: rtl/wbsplit_pkg.sv
// Shared types and default address map for the Wishbone splitter.
package wbsplit_pkg;

   // Owner of a request: which slave (if any) an address decodes to.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2
   } sel_t;

   localparam int unsigned DEF_AW     = 19;
   localparam int unsigned DEF_DW     = 32;
   localparam int unsigned DEF_LGPIPE = 4;

   localparam logic [DEF_AW-1:0] DEF_A_BASE = 19'h00000;
   localparam logic [DEF_AW-1:0] DEF_A_MASK = 19'h40000;
   localparam logic [DEF_AW-1:0] DEF_B_BASE = 19'h40000;
   localparam logic [DEF_AW-1:0] DEF_B_MASK = 19'h60000;

endpackage

// File: rtl/wbsplitter_if.sv
// Pipelined Wishbone bus bundle; master drives requests, slave drives responses.
interface wbsplitter_if
   import wbsplit_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat;
   logic [DW/8-1:0] sel;
   logic            ack;
   logic            stall;
   logic            err;
   logic [DW-1:0]   data;

   modport master (
      output cyc, stb, we, adr, dat, sel,
      input  ack, stall, err, data
   );

   modport slave (
      input  cyc, stb, we, adr, dat, sel,
      output ack, stall, err, data
   );
endinterface

// File: rtl/wbsplit_decode.sv
// Address decoder: maps a word address onto slave A, slave B or nothing.
module wbsplit_decode
   import wbsplit_pkg::*;
#(
   parameter int unsigned    AW     = DEF_AW,
   parameter logic [AW-1:0]  A_BASE = DEF_A_BASE,
   parameter logic [AW-1:0]  A_MASK = DEF_A_MASK,
   parameter logic [AW-1:0]  B_BASE = DEF_B_BASE,
   parameter logic [AW-1:0]  B_MASK = DEF_B_MASK
) (
   input  logic [AW-1:0] i_adr,
   output sel_t          o_sel
);

   // A wins when both windows match.
   always_comb begin
      o_sel = SEL_NONE;
      if ((i_adr & A_MASK) == A_BASE) begin
         o_sel = SEL_A;
      end else if ((i_adr & B_MASK) == B_BASE) begin
         o_sel = SEL_B;
      end
   end

endmodule

// File: rtl/wbsplitter.sv
// Single-master to dual-slave pipelined Wishbone splitter with local bus error
// for unmapped addresses and drain-before-switch target ordering.
module wbsplitter
   import wbsplit_pkg::*;
#(
   parameter int unsigned    DW     = DEF_DW,
   parameter int unsigned    AW     = DEF_AW,
   parameter logic [AW-1:0]  A_BASE = DEF_A_BASE,
   parameter logic [AW-1:0]  A_MASK = DEF_A_MASK,
   parameter logic [AW-1:0]  B_BASE = DEF_B_BASE,
   parameter logic [AW-1:0]  B_MASK = DEF_B_MASK,
   parameter int unsigned    LGPIPE = DEF_LGPIPE
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   wbsplitter_if.slave  cpu,
   wbsplitter_if.master a_bus,
   wbsplitter_if.master b_bus
);

   localparam logic [LGPIPE-1:0] CountMax = '1;

   sel_t              dec;
   sel_t              sel_q, sel_d;
   logic [LGPIPE-1:0] count_q, count_d;
   logic              berr_q, berr_d;
   logic              abort_q, abort_d;

   logic              busy, full, req;
   logic              stall_local, slave_stall, stall;
   logic              accept, accept_slave;
   logic              a_stb, b_stb;
   logic              sel_ack, sel_err;
   logic              ack, err;
   logic [DW-1:0]     rd_data;

   wbsplit_decode #(
      .AW     (AW),
      .A_BASE (A_BASE),
      .A_MASK (A_MASK),
      .B_BASE (B_BASE),
      .B_MASK (B_MASK)
   ) u_decode (
      .i_adr (cpu.adr),
      .o_sel (dec)
   );

   // Request path: stall causes, per-slave strobes and the accept qualifier.
   always_comb begin
      busy        = (count_q != '0);
      full        = (count_q == CountMax);
      // Everything except the target's own stall; this also gates the strobe.
      stall_local = abort_q | berr_q | full
                  | (busy & (dec != sel_q))
                  | (busy & (dec == SEL_NONE));
      slave_stall = 1'b0;
      unique case (dec)
         SEL_A:   slave_stall = a_bus.stall;
         SEL_B:   slave_stall = b_bus.stall;
         default: slave_stall = 1'b0;
      endcase
      stall        = stall_local | slave_stall;
      // Reset gates the strobes so nothing leaks to the slaves while held.
      req          = i_rst_n & cpu.cyc & cpu.stb;
      accept       = req & ~stall;
      accept_slave = accept & (dec != SEL_NONE);
      a_stb        = req & (dec == SEL_A) & ~stall_local;
      b_stb        = req & (dec == SEL_B) & ~stall_local;
   end

   // Response path: only the slave owning the outstanding requests is heard.
   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      rd_data = a_bus.data;
      unique case (sel_q)
         SEL_A: begin
            sel_ack = a_bus.ack;
            sel_err = a_bus.err;
            rd_data = a_bus.data;
         end
         SEL_B: begin
            sel_ack = b_bus.ack;
            sel_err = b_bus.err;
            rd_data = b_bus.data;
         end
         default: begin
            sel_ack = 1'b0;
            sel_err = 1'b0;
         end
      endcase
      ack = cpu.cyc & busy & sel_ack;
      err = berr_q | (cpu.cyc & busy & sel_err);
   end

   // Next state for target, outstanding count, local error and abort.
   always_comb begin
      sel_d   = sel_q;
      count_d = count_q;
      berr_d  = berr_q;
      abort_d = abort_q;
      if (!cpu.cyc) begin
         sel_d   = SEL_NONE;
         count_d = '0;
         berr_d  = 1'b0;
         abort_d = 1'b0;
      end else if (err) begin
         // Error ends the transfer; stay stalled until the master drops cyc.
         count_d = '0;
         berr_d  = 1'b0;
         abort_d = 1'b1;
      end else begin
         if (accept_slave) begin
            sel_d = dec;
         end
         if (accept && (dec == SEL_NONE)) begin
            berr_d = 1'b1;
         end
         count_d = count_q + {{(LGPIPE-1){1'b0}}, accept_slave}
                           - {{(LGPIPE-1){1'b0}}, ack};
      end
   end

   // State registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_q   <= SEL_NONE;
         count_q <= '0;
         berr_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         count_q <= count_d;
         berr_q  <= berr_d;
         abort_q <= abort_d;
      end
   end

   assign cpu.ack   = ack;
   assign cpu.err   = err;
   assign cpu.stall = stall;
   assign cpu.data  = rd_data;

   assign a_bus.cyc = i_rst_n & cpu.cyc & ~abort_q & (((sel_q == SEL_A) & busy) | a_stb);
   assign a_bus.stb = a_stb;
   assign a_bus.we  = cpu.we;
   assign a_bus.adr = cpu.adr;
   assign a_bus.dat = cpu.dat;
   assign a_bus.sel = cpu.sel;

   assign b_bus.cyc = i_rst_n & cpu.cyc & ~abort_q & (((sel_q == SEL_B) & busy) | b_stb);
   assign b_bus.stb = b_stb;
   assign b_bus.we  = cpu.we;
   assign b_bus.adr = cpu.adr;
   assign b_bus.dat = cpu.dat;
   assign b_bus.sel = cpu.sel;

endmodule

// File: tb/tb_wbsplitter.sv
// Directed bench for wbsplitter with a response scoreboard on the master side.
module tb_wbsplitter;
   import wbsplit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   wbsplitter_if cpu ();
   wbsplitter_if a_bus ();
   wbsplitter_if b_bus ();

   wbsplitter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .cpu     (cpu),
      .a_bus   (a_bus),
      .b_bus   (b_bus)
   );

   typedef struct {
      logic        is_err;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp_v);
      end
   endtask

   task automatic expect_ack(input logic [31:0] d, input logic chk);
      exp_t e;
      e.is_err = 1'b0;
      e.chk_data = chk;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      e.is_err = 1'b1;
      e.chk_data = 1'b0;
      e.data = '0;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
      cpu.adr = '0;   cpu.dat = '0;   cpu.sel = 4'hf;
      a_bus.ack = 1'b0; a_bus.err = 1'b0; a_bus.stall = 1'b0; a_bus.data = '0;
      b_bus.ack = 1'b0; b_bus.err = 1'b0; b_bus.stall = 1'b0; b_bus.data = '0;
   endtask

   // Monitor: every master-side response must match the head of the scoreboard.
   always @(negedge clk) begin
      if (cpu.ack === 1'b1 || cpu.err === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got ack=%b err=%b data=%h, required no response",
                     cpu.ack, cpu.err, cpu.data);
         end else begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            if (e.is_err) ok = cpu.err && !cpu.ack;
            else          ok = cpu.ack && !cpu.err && (!e.chk_data || cpu.data == e.data);
            if (!ok) begin
               errors++;
               $display("FAIL resp: got ack=%b err=%b data=%h, required %s data=%h",
                        cpu.ack, cpu.err, cpu.data, e.is_err ? "err" : "ack", e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic seen;

      // Reset held with an active master request and a spurious slave ack.
      idle_all();
      cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.adr = 19'h00010; a_bus.ack = 1'b1;
      @(negedge clk);
      check("rst_ack",   cpu.ack,   0);
      check("rst_err",   cpu.err,   0);
      check("rst_a_cyc", a_bus.cyc, 0);
      check("rst_a_stb", a_bus.stb, 0);
      check("rst_b_cyc", b_bus.cyc, 0);
      next_cycle();
      idle_all();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // T1: three pipelined reads to A, ack latency 2, data A0..A2.
      seen = 1'b0;
      cpu.cyc = 1'b1; cpu.we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu.stb    = (i < 3);
         cpu.adr    = 19'h00010 + 19'(i);
         a_bus.ack  = (i >= 2);
         a_bus.data = 32'h000000A0 + 32'(i - 2);
         if (i >= 2) expect_ack(32'h000000A0 + 32'(i - 2), 1'b1);
         @(negedge clk);
         if (i < 3) check("t1_stall", cpu.stall, 0);
         check("t1_a_stb", a_bus.stb, (i < 3));
         if (b_bus.cyc) seen = 1'b1;
         next_cycle();
      end
      idle_all();
      check("t1_b_cyc_never", seen, 0);
      next_cycle();

      // T2: write to A then B; B strobe waits for A's ack to drain.
      n = 0;
      cpu.cyc = 1'b1; cpu.we = 1'b1; cpu.dat = 32'h12345678;
      for (int i = 0; i < 6; i++) begin
         cpu.stb   = (i <= 4);
         cpu.adr   = (i == 0) ? 19'h00004 : 19'h40004;
         a_bus.ack = (i == 3);
         b_bus.ack = (i == 5);
         if (i == 3 || i == 5) expect_ack('0, 1'b0);
         @(negedge clk);
         if (i <= 4) check("t2_stall", cpu.stall, (i >= 1 && i <= 3));
         check("t2_a_stb", a_bus.stb, (i == 0));
         check("t2_b_stb", b_bus.stb, (i == 4));
         if (b_bus.stb) n++;
         next_cycle();
      end
      idle_all();
      check("t2_b_stb_cycles", n, 1);
      next_cycle();

      // T3: unmapped read -> local error the next cycle, then abort stall.
      cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.adr = 19'h60000;
      @(negedge clk);
      check("t3_a_stb0", a_bus.stb, 0);
      check("t3_b_stb0", b_bus.stb, 0);
      check("t3_stall0", cpu.stall, 0);
      check("t3_err0",   cpu.err,   0);
      next_cycle();
      cpu.adr = 19'h00010;
      expect_err();
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("t3_stall", cpu.stall, 1);
         check("t3_a_stb", a_bus.stb, 0);
         check("t3_err",   cpu.err,   (i == 1));
         next_cycle();
      end
      cpu.cyc = 1'b0; cpu.stb = 1'b0;
      next_cycle();
      cpu.cyc = 1'b1; cpu.stb = 1'b1;
      @(negedge clk);
      check("t3_recover_stall", cpu.stall, 0);
      check("t3_recover_a_stb", a_bus.stb, 1);
      next_cycle();
      idle_all();
      next_cycle();

      // T4: fill the pipeline; A never acks except one release ack.
      n = 0;
      cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.adr = 19'h00020;
      a_bus.data = 32'h000000B0;
      for (int i = 0; i < 20; i++) begin
         a_bus.ack = (i == 17);
         if (i == 17) expect_ack(32'h000000B0, 1'b1);
         @(negedge clk);
         if (!cpu.stall) n++;
         if (i == 16) check("t4_accepted_15", n, 15);
         if (i >= 15 && i <= 17) check("t4_stall_full", cpu.stall, 1);
         if (i == 18) check("t4_release", cpu.stall, 0);
         if (i == 19) check("t4_refull", cpu.stall, 1);
         next_cycle();
      end
      idle_all();
      check("t4_accepted_total", n, 16);
      next_cycle();

      // T5: B errors with two outstanding; a late B ack is dropped.
      cpu.cyc = 1'b1; cpu.stb = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cpu.adr = 19'h40000 + 19'(i);
         @(negedge clk);
         check("t5_stall", cpu.stall, 0);
         check("t5_b_stb", b_bus.stb, 1);
         next_cycle();
      end
      cpu.stb = 1'b0; b_bus.err = 1'b1;
      expect_err();
      @(negedge clk);
      check("t5_err",       cpu.err,   1);
      check("t5_b_cyc_hi",  b_bus.cyc, 1);
      next_cycle();
      b_bus.err = 1'b0;
      @(negedge clk);
      check("t5_b_cyc_drop", b_bus.cyc, 0);
      check("t5_err_once",   cpu.err,   0);
      next_cycle();
      b_bus.ack = 1'b1;
      @(negedge clk);
      check("t5_late_ack", cpu.ack, 0);
      next_cycle();
      idle_all();
      next_cycle();

      // T6: reset pulse with three outstanding reads to A.
      cpu.cyc = 1'b1; cpu.stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu.adr = 19'h00030 + 19'(i);
         @(negedge clk);
         check("t6_stall", cpu.stall, 0);
         next_cycle();
      end
      cpu.adr = 19'h00033; a_bus.ack = 1'b1;
      rst_n = 1'b0;
      #1;
      check("t6_a_cyc", a_bus.cyc, 0);
      check("t6_a_stb", a_bus.stb, 0);
      check("t6_b_cyc", b_bus.cyc, 0);
      check("t6_b_stb", b_bus.stb, 0);
      check("t6_ack",   cpu.ack,   0);
      check("t6_err",   cpu.err,   0);
      next_cycle();
      rst_n = 1'b1; cpu.stb = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t6_post_ack",   cpu.ack,   0);
         check("t6_post_a_cyc", a_bus.cyc, 0);
         next_cycle();
      end
      idle_all();
      next_cycle();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wbsplitter.md
# wbsplitter

Single-master to dual-slave pipelined Wishbone splitter: the fan-out counterpart to the two-master arbiter. It address-decodes each strobe to slave A or slave B, tracks outstanding requests, and routes ack/err/read-data back from the slave that owns them. It stalls any target switch until the pipeline drains, and answers unmapped addresses with a locally generated bus error. It sits between the CPU-side bus (typically the arbiter output) and two peripheral groups.

## Interface
- DW, 32: data width
- AW, 19: word-address width
- A_BASE, 19'h00000: slave A match value
- A_MASK, 19'h40000: slave A match mask; A hit when (i_adr & A_MASK) == A_BASE
- B_BASE, 19'h40000: slave B match value
- B_MASK, 19'h60000: slave B match mask
- LGPIPE, 4: log2 outstanding-request capacity; maximum outstanding is 2^LGPIPE-1
- i_clk  in  1  clock; everything rising-edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_cyc, i_stb, i_we  in  1 each  master cycle/strobe/write
- i_adr  in  AW  master address
- i_dat  in  DW  master write data
- i_sel  in  DW/8  master byte selects
- o_ack, o_stall, o_err  out  1 each  master responses
- o_data  out  DW  master read data
- o_a_cyc, o_a_stb, o_a_we  out  1 each  slave A controls (B: o_b_*)
- o_a_adr, o_a_dat, o_a_sel  out  AW/DW/DW/8  slave A request fields, driven from the master inputs (B identical)
- i_a_ack, i_a_stall, i_a_err  in  1 each  slave A responses (B: i_b_*)
- i_a_data  in  DW  slave A read data (B: i_b_data)

## Operation
- Decode: A hit takes priority over B hit; a miss on both is unmapped (NONE).
- State: r_sel ∈ {NONE, A, B}; r_count, LGPIPE bits; r_berr, a pending local error; r_abort.
- Accept = i_cyc & i_stb & ~o_stall.
- o_stall is 1 if any of the following hold:
  - r_abort or r_berr;
  - r_count == 2^LGPIPE-1;
  - r_count != 0 and decoded target != r_sel;
  - decoded target is NONE and r_count != 0;
  - the decoded slave's i_x_stall.
- On accept to A or B: r_sel <= target.
- On accept to NONE: r_berr <= 1, and no slave is strobed.
- r_count next = r_count + (accept to A/B) − o_ack.
- o_x_stb = i_cyc & i_stb & decode==x & ~(o_stall due to any cause other than i_x_stall).
- o_x_cyc = i_cyc & ~r_abort & ((r_sel==x & r_count!=0) | decode-driven o_x_stb).
- o_ack = i_cyc & r_count!=0 & selected slave's ack.
- o_data is muxed by r_sel. It is don't-care when o_ack is low.
- o_err = r_berr | (i_cyc & r_count!=0 & selected slave's err).
- Any o_err sets r_abort and clears r_count and r_berr.
- Responses from the non-selected slave are ignored.
- A slave ack arriving while r_count == 0 is ignored.
- i_cyc low: r_count <= 0, r_berr <= 0, r_abort <= 0, r_sel <= NONE next edge. Both o_x_cyc drop the same cycle (combinational).

## Timing
- Reset is asynchronous and active-low; it is the only reset. While asserted: r_count = 0, r_sel = NONE, r_berr = 0, r_abort = 0.
- While reset is asserted, o_ack = o_err = 0 and o_a_cyc = o_a_stb = o_b_cyc = o_b_stb = 0.
- Request path and response path are combinational: zero added latency.
- Unmapped error: o_err is high exactly one cycle, the cycle after accept.
- Target switch: the first strobe to the new slave is accepted on the cycle after the old slave's final ack, i.e. on the cycle r_count reads 0.
- Simultaneous accept and ack: r_count is unchanged.
- Full: at r_count = 15, o_stall = 1. A same-cycle ack does not release the stall until the next cycle.
- Reset mid-transfer: outstanding state is lost. Late slave acks after reset are dropped because r_count == 0.

## Structure
- Package wbsplit_pkg holds the sel enum (SEL_NONE, SEL_A, SEL_B) and default base/mask constants.
- One sub-module, wbsplit_decode: purely combinational; AW address plus base/mask parameters in, sel enum out.
- Counter, error, and abort logic live in wbsplitter.

## Test plan
- Three pipelined reads to 0x00010..0x00012, slave A acking at 2-cycle latency with data 0xA0..0xA2 -> three o_ack, o_data in order, o_b_cyc never high.
- Write to 0x00004, then immediate write to 0x40004, A ack after 3 cycles -> second strobe stalled until the cycle after A's ack; o_b_stb then high for 1 cycle.
- Read at 0x60000 with r_count = 0 -> no slave strobe; o_err = 1 the next cycle only; following strobes stalled until i_cyc drops.
- 16 back-to-back strobes to A, slave never acks -> exactly 15 accepted, o_stall held; one ack releases exactly one more.
- Slave B asserts i_b_err with 2 outstanding -> o_err one cycle, o_b_cyc drops; a later i_b_ack is not forwarded.
- i_rst_n pulsed low mid-burst with 3 outstanding -> all slave cyc/stb and o_ack/o_err 0 immediately; post-reset acks ignored.
